fetch_stage: RTL

- Instruction fetch (IF) stage: the producer end of the core's valid/ready pipeline, whose consumer end is write-back.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents them downstream with valid_out/ready_in.
- Redirects on trap_taken_csr/trap_addr_csr (driven by write-back/CSR) and on branch_taken/branch_addr (from execute), discarding all stale in-flight responses.

---
 rtl/fetch_stage_if.sv | 20 ++
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory channel between the fetch stage (master) and memory (slave):
// valid/ready request plus an in-order, always-accepted response.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_error;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_error
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_error
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, registered instruction FIFO
// and redirect handling. Define FETCH_PERF_EN to build the fetch/flush performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic                 trap_taken_csr,
    input  logic [31:0]          trap_addr_csr,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_addr,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [31:0]          PC_IF,
    output logic [31:0]          IR_IF,
    output logic                 exc_pend_IF,
    output logic [31:0]          exc_cause_IF,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_flush_cnt
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OutW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QPtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q;
    logic [OutW-1:0] inflight_q, discard_q, outstanding;
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic [QPtrW-1:0] pcq_rd_q, pcq_wr_q;

    logic [31:0] fifo_pc    [FIFO_DEPTH];
    logic [31:0] fifo_ir    [FIFO_DEPTH];
    logic        fifo_exc   [FIFO_DEPTH];
    logic        fifo_cause [FIFO_DEPTH];
    logic [31:0] pcq        [MAX_OUTSTANDING];

    logic        redirect, req_valid, req_fire, mis_push;
    logic        rsp_drop, rsp_push, push, pop;
    logic [31:0] redirect_addr, push_pc, push_ir;
    logic        push_exc, push_cause;

    function automatic logic [QPtrW-1:0] qinc(input logic [QPtrW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + QPtrW'(1);
    endfunction

    assign redirect      = trap_taken_csr | branch_taken;
    assign redirect_addr = trap_taken_csr ? trap_addr_csr : branch_addr;
    // Requests still owed by memory once this cycle's response is counted.
    assign outstanding   = inflight_q - OutW'(imem.imem_rsp_valid);
    assign rsp_drop      = imem.imem_rsp_valid && (discard_q != '0 || redirect);
    assign rsp_push      = imem.imem_rsp_valid && !rsp_drop;
    assign req_fire      = req_valid && imem.imem_req_ready;
    assign push          = rsp_push || mis_push;
    assign valid_out     = !reset && (count_q != '0);
    assign pop           = valid_out && ready_in;

    assign push_pc    = mis_push ? pc_q : pcq[pcq_rd_q];
    assign push_ir    = mis_push ? 32'h0 : imem.imem_rsp_data;
    assign push_exc   = mis_push | imem.imem_rsp_error;
    assign push_cause = !mis_push;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StRun;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect)                                         state_d = StRun;
        else if ((rsp_push && imem.imem_rsp_error) || mis_push) state_d = StHalt;
    end

    always_comb begin
        req_valid = 1'b0;
        mis_push  = 1'b0;
        if (!reset && state_q == StRun && !redirect) begin
            if (pc_q[1:0] == 2'b00) begin
                req_valid = (32'(inflight_q) + 32'(count_q) < FIFO_DEPTH) &&
                            (32'(inflight_q) < MAX_OUTSTANDING);
            end else begin
                // Only reachable right after a redirect, so no kept response competes.
                mis_push = (32'(count_q) < FIFO_DEPTH) && !rsp_push;
            end
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;

    // Reset keeps counting requests memory still owes so their late responses get dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_ADDR;
            inflight_q <= outstanding;
            discard_q  <= outstanding;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            if (redirect)      pc_q <= redirect_addr;
            else if (req_fire) pc_q <= pc_q + 32'd4;
            inflight_q <= outstanding + OutW'(req_fire);
            if (redirect)                                          discard_q <= outstanding;
            else if (imem.imem_rsp_valid && discard_q != '0)       discard_q <= discard_q - OutW'(1);
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                pcq_rd_q <= '0;
                pcq_wr_q <= '0;
            end else begin
                if (push)     wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)      rd_ptr_q <= rd_ptr_q + PtrW'(1);
                count_q <= count_q + CntW'(push) - CntW'(pop);
                if (req_fire) pcq_wr_q <= qinc(pcq_wr_q);
                if (rsp_push) pcq_rd_q <= qinc(pcq_rd_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_ir[i]    <= '0;
                fifo_exc[i]   <= 1'b0;
                fifo_cause[i] <= 1'b0;
            end
        end else if (push && !redirect) begin
            fifo_pc[wr_ptr_q]    <= push_pc;
            fifo_ir[wr_ptr_q]    <= push_ir;
            fifo_exc[wr_ptr_q]   <= push_exc;
            fifo_cause[wr_ptr_q] <= push_cause;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) pcq[pcq_wr_q] <= pc_q;
    end

    assign PC_IF        = fifo_pc[rd_ptr_q];
    assign IR_IF        = fifo_ir[rd_ptr_q];
    assign exc_pend_IF  = fifo_exc[rd_ptr_q];
    assign exc_cause_IF = {31'h0, fifo_cause[rd_ptr_q]};

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pop && !fifo_exc[rd_ptr_q]) perf_fetch_q <= perf_fetch_q + 32'd1;
            perf_flush_q <= perf_flush_q + 32'(rsp_drop) +
                            (redirect ? (32'(count_q) - 32'(pop)) : 32'd0);
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule
